instr_mem_resp64: RTL and testbench
===================================

# instr_mem_resp64

Responder end of the 64-bit instruction fetch bus (req/gnt/addr, rvalid/rdata/err) driven by the core's prefetch buffer. It accepts doubleword fetch requests, issues them to a single-port fixed-latency SRAM macro, and returns in-order responses. Out-of-window fetches receive an error response. A data-side write port shares the macro for code loading, and a write always wins a cycle.

## Interface
- BaseAddr, 32'h8000_0000, byte base of the memory window; must be 8-byte aligned.
- MemWords, 4096, number of 64-bit words; BaseAddr + 8*MemWords must not exceed 2^32.
- MemLatency, 1, cycles from mem_req_o to valid mem_rdata_i; legal range 1..4.
- MaxOutstanding, 2, maximum granted-but-unanswered fetches; legal range 1..4.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- instr_req_i  in  1  fetch request; the initiator holds it and instr_addr_i stable until granted.
- instr_addr_i  in  32  fetch byte address; bits [2:0] are ignored.
- instr_gnt_o  out  1  request accepted this cycle.
- instr_rvalid_o  out  1  response valid; the initiator cannot stall a response.
- instr_rdata_o  out  64  doubleword at addr[31:3]; 0 on error.
- instr_err_o  out  1  error response; qualified by instr_rvalid_o.
- wr_req_i  in  1  write request.
- wr_addr_i  in  32  write byte address; bits [2:0] are ignored.
- wr_wdata_i  in  64  write data.
- wr_be_i  in  8  byte enables.
- wr_gnt_o  out  1  write accepted; this is a single-cycle operation.
- mem_req_o  out  1  macro access.
- mem_we_o  out  1  macro write.
- mem_addr_o  out  $clog2(MemWords)  word index.
- mem_wdata_o  out  64  macro write data.
- mem_be_o  out  8  macro byte enables.
- mem_rdata_i  in  64  macro read data, valid MemLatency cycles after the read.

## Operation
- Window check: in_range = (addr >= BaseAddr) && (addr < BaseAddr + 8*MemWords). Compute it in 33 bits, with no wrap.
- Word index = (addr - BaseAddr) >> 3, truncated to the mem_addr_o width.
- Write arbitration:
  - wr_gnt_o = wr_req_i, always granted.
  - An in-range write drives mem_req_o=1, mem_we_o=1, and passes wdata and be.
  - An out-of-range write is granted and dropped with no macro access.
- Fetch grant:
  - instr_gnt_o = instr_req_i & ~wr_req_i & (outstanding - retire < MaxOutstanding).
  - retire = the response emitted this cycle.
- Granted fetch, in range: mem_req_o=1, mem_we_o=0.
- Granted fetch, out of range: no macro access.
- Every granted fetch enters a MemLatency-deep shift pipe carrying {valid, err}.
- Response stage:
  - instr_rvalid_o is the last pipe stage valid, which is registered.
  - instr_err_o is the last stage err.
  - instr_rdata_o = err ? 0 : mem_rdata_i, a combinational mux.
- Outstanding counter:
  - Width $clog2(MaxOutstanding+1).
  - +1 on a fetch grant, -1 on instr_rvalid_o, unchanged when both occur.
  - Never exceeds MaxOutstanding and never underflows. Either event is an assertion failure.
- Responses return strictly in grant order; error responses occupy their slot in order.

## Timing
- Reset values:
  - Pipe and counter cleared.
  - instr_rvalid_o=0, instr_err_o=0, instr_rdata_o=0.
  - instr_gnt_o=0, wr_gnt_o=0, mem_req_o=0, mem_we_o=0, all held while rst_i=1.
- A fetch granted in cycle N gets its response in cycle N+MemLatency.
- Throughput is 1 fetch/cycle when MaxOutstanding >= MemLatency. Otherwise it is MaxOutstanding per MemLatency cycles.
- Full counter: a grant is still allowed in a cycle where a response retires.
- Simultaneous wr_req_i and instr_req_i: the write is granted and instr_gnt_o=0. The fetch retries the next cycle, with no change in ordering.
- A write in cycle N is visible to a fetch granted in cycle N+1 or later.
- Reset mid-operation: in-flight responses are discarded, and no rvalid follows reset release for pre-reset grants.
- No request: outputs hold at idle, rvalid=0.

## Test plan
- Back-to-back in-range fetch:
  - Stimulus: MemLatency=1, MaxOutstanding=2, word k preloaded with 64'h0000_0000_0000_1000+k; instr_req_i held at addrs 8000_0000, 8000_0008, 8000_0010.
  - Response: gnt in 3 consecutive cycles; rvalid 1 cycle after each gnt, with data 1000, 1001, 1002 and err=0.
- Ignored low bits: addr 8000_0004 returns the same data as 8000_0000.
- Window boundaries:
  - Fetch 8000_7FF8 (MemWords=4096) returns word 4095 with err=0.
  - Fetch 8000_8000 returns err=1, rdata=0, and no mem_req_o.
  - Fetch 7FFF_FFF8 returns err=1.
- Outstanding limit: MemLatency=3, MaxOutstanding=2, continuous requests give the gnt pattern 1,1,0,1,1,0…; the counter never exceeds 2.
- Write priority and ordering: a write of 64'hDEAD_BEEF_0BAD_F00D with be=8'hFF to 8000_0010 collides with a fetch of 8000_0010 in the same cycle. Required response:
  - wr_gnt_o=1, instr_gnt_o=0 that cycle.
  - The fetch is granted the next cycle and returns DEAD_BEEF_0BAD_F00D.
- Mid-flight reset: assert rst_i the cycle after 2 grants with MemLatency=2. Required response: instr_rvalid_o stays 0 through and after reset release.

Source files
------------

// File: rtl/instr_mem_resp64.sv
// Instruction-fetch responder: in-order 64-bit fetch responses from a fixed-latency
// single-port SRAM macro, with a data-side write port that always wins the macro.
module instr_mem_resp64 #(
  parameter logic [31:0] BaseAddr       = 32'h8000_0000,
  parameter int          MemWords       = 4096,
  parameter int          MemLatency     = 1,
  parameter int          MaxOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        instr_req_i,
  input  logic [31:0]                 instr_addr_i,
  output logic                        instr_gnt_o,
  output logic                        instr_rvalid_o,
  output logic [63:0]                 instr_rdata_o,
  output logic                        instr_err_o,
  input  logic                        wr_req_i,
  input  logic [31:0]                 wr_addr_i,
  input  logic [63:0]                 wr_wdata_i,
  input  logic [7:0]                  wr_be_i,
  output logic                        wr_gnt_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [$clog2(MemWords)-1:0] mem_addr_o,
  output logic [63:0]                 mem_wdata_o,
  output logic [7:0]                  mem_be_o,
  input  logic [63:0]                 mem_rdata_i
);

  localparam int          DATA_W = 64;
  localparam int          AW     = $clog2(MemWords);
  localparam int          CW     = $clog2(MaxOutstanding + 1);
  localparam logic [32:0] WinLo  = {1'b0, BaseAddr};
  // Upper bound is computed in 33 bits so a window ending at 2^32 does not wrap.
  localparam logic [32:0] WinHi  = {1'b0, BaseAddr} + (33'(MemWords) << 3);
  localparam logic [CW:0] MaxOcc = (CW + 1)'(MaxOutstanding);
  localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

  function automatic logic in_window(input logic [31:0] addr);
    logic [32:0] a;
    a = {1'b0, addr[31:3], 3'b000};
    return (a >= WinLo) && (a < WinHi);
  endfunction

  logic [31:0]           fetch_off;
  logic [31:0]           wr_off;
  logic                  fetch_hit;
  logic                  wr_hit;
  logic                  fetch_gnt;
  logic                  wr_access;
  logic                  rd_access;
  logic                  retire;
  logic [CW-1:0]         outstanding;
  logic [CW:0]           occ_after;
  logic [MemLatency-1:0] vld_p;
  logic [MemLatency-1:0] err_p;
  logic                  unused_bits;

  assign fetch_off   = instr_addr_i - BaseAddr;
  assign wr_off      = wr_addr_i - BaseAddr;
  assign fetch_hit   = in_window(instr_addr_i);
  assign wr_hit      = in_window(wr_addr_i);
  assign unused_bits = ^{fetch_off, wr_off, instr_addr_i[2:0], wr_addr_i[2:0]};

  // A response retiring this cycle frees its slot for a same-cycle grant.
  assign retire    = vld_p[MemLatency-1];
  assign occ_after = {1'b0, outstanding} - {{CW{1'b0}}, retire};
  assign fetch_gnt = ~rst_i & instr_req_i & ~wr_req_i & (occ_after < MaxOcc);

  assign wr_gnt_o    = ~rst_i & wr_req_i;
  assign instr_gnt_o = fetch_gnt;
  assign wr_access   = wr_gnt_o & wr_hit;
  assign rd_access   = fetch_gnt & fetch_hit;

  // Macro port: the write owns the address whenever one is requested.
  assign mem_req_o   = wr_access | rd_access;
  assign mem_we_o    = wr_access;
  assign mem_addr_o  = wr_req_i ? wr_off[AW+2:3] : fetch_off[AW+2:3];
  assign mem_wdata_o = wr_wdata_i;
  assign mem_be_o    = wr_access ? wr_be_i : 8'h00;

  // Stage p0 captures the grant; stage p[MemLatency-1] lines up with mem_rdata_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p <= '0;
      err_p <= '0;
    end else begin
      vld_p[0] <= fetch_gnt;
      err_p[0] <= fetch_gnt & ~fetch_hit;
      for (int i = 1; i < MemLatency; i++) begin
        vld_p[i] <= vld_p[i-1];
        err_p[i] <= err_p[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else begin
      case ({fetch_gnt, retire})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Response stage: data is steered straight from the macro, zeroed on error or idle.
  logic [DATA_W-1:0] rdata_sel;
  assign rdata_sel      = (retire & ~err_p[MemLatency-1]) ? mem_rdata_i : '0;
  assign instr_rvalid_o = retire;
  assign instr_err_o    = err_p[MemLatency-1];
  assign instr_rdata_o  = rdata_sel;

  a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
    outstanding <= MaxCnt);
  a_cnt_over: assert property (@(posedge clk_i) disable iff (rst_i)
    !(fetch_gnt && !retire && outstanding == MaxCnt));
  a_cnt_under: assert property (@(posedge clk_i) disable iff (rst_i)
    !(retire && !fetch_gnt && outstanding == '0));

endmodule

// File: tb/tb_instr_mem_resp64.sv
// Directed bench for instr_mem_resp64: three instances cover latency 1, 3 and 2.
module tb_instr_mem_resp64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- instance A: MemLatency=1, MaxOutstanding=2, real memory
  logic        a_rst, a_req, a_gnt, a_rvalid, a_err;
  logic [31:0] a_addr, a_wr_addr;
  logic [63:0] a_rdata, a_wr_wdata, a_mem_wdata, a_mem_rdata;
  logic        a_wr_req, a_wr_gnt, a_mem_req, a_mem_we;
  logic [7:0]  a_wr_be, a_mem_be;
  logic [11:0] a_mem_addr;
  logic [63:0] mem_a [4096];

  instr_mem_resp64 #(.MemLatency(1), .MaxOutstanding(2)) u_a (
    .clk_i(clk), .rst_i(a_rst),
    .instr_req_i(a_req), .instr_addr_i(a_addr), .instr_gnt_o(a_gnt),
    .instr_rvalid_o(a_rvalid), .instr_rdata_o(a_rdata), .instr_err_o(a_err),
    .wr_req_i(a_wr_req), .wr_addr_i(a_wr_addr), .wr_wdata_i(a_wr_wdata),
    .wr_be_i(a_wr_be), .wr_gnt_o(a_wr_gnt),
    .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
    .mem_wdata_o(a_mem_wdata), .mem_be_o(a_mem_be), .mem_rdata_i(a_mem_rdata));

  always @(posedge clk) begin
    if (a_rst) begin
      for (int k = 0; k < 4096; k++) mem_a[k] <= 64'h1000 + 64'(k);
    end else if (a_mem_req) begin
      if (a_mem_we) begin
        for (int b = 0; b < 8; b++)
          if (a_mem_be[b]) mem_a[a_mem_addr][8*b +: 8] <= a_mem_wdata[8*b +: 8];
      end else begin
        a_mem_rdata <= mem_a[a_mem_addr];
      end
    end
  end

  // ---------------- instance B: MemLatency=3, MaxOutstanding=2, data = word index
  logic        b_rst, b_req, b_gnt, b_rvalid, b_err;
  logic [31:0] b_addr;
  logic [63:0] b_rdata, b_mem_rdata;
  logic        b_unused_wgnt, b_unused_req, b_unused_we;
  logic [63:0] b_unused_wdata;
  logic [7:0]  b_unused_be;
  logic [11:0] b_mem_addr;
  logic [63:0] b_s [3];

  instr_mem_resp64 #(.MemLatency(3), .MaxOutstanding(2)) u_b (
    .clk_i(clk), .rst_i(b_rst),
    .instr_req_i(b_req), .instr_addr_i(b_addr), .instr_gnt_o(b_gnt),
    .instr_rvalid_o(b_rvalid), .instr_rdata_o(b_rdata), .instr_err_o(b_err),
    .wr_req_i(1'b0), .wr_addr_i(32'h0), .wr_wdata_i(64'h0),
    .wr_be_i(8'h0), .wr_gnt_o(b_unused_wgnt),
    .mem_req_o(b_unused_req), .mem_we_o(b_unused_we), .mem_addr_o(b_mem_addr),
    .mem_wdata_o(b_unused_wdata), .mem_be_o(b_unused_be), .mem_rdata_i(b_mem_rdata));

  always @(posedge clk) begin
    b_s[0] <= {52'h0, b_mem_addr};
    b_s[1] <= b_s[0];
    b_s[2] <= b_s[1];
  end
  assign b_mem_rdata = b_s[2];

  // ---------------- instance C: MemLatency=2, MaxOutstanding=2, data = word index
  logic        c_rst, c_req, c_gnt, c_rvalid, c_err;
  logic [31:0] c_addr;
  logic [63:0] c_rdata, c_mem_rdata;
  logic        c_unused_wgnt, c_unused_req, c_unused_we;
  logic [63:0] c_unused_wdata;
  logic [7:0]  c_unused_be;
  logic [11:0] c_mem_addr;
  logic [63:0] c_s [2];

  instr_mem_resp64 #(.MemLatency(2), .MaxOutstanding(2)) u_c (
    .clk_i(clk), .rst_i(c_rst),
    .instr_req_i(c_req), .instr_addr_i(c_addr), .instr_gnt_o(c_gnt),
    .instr_rvalid_o(c_rvalid), .instr_rdata_o(c_rdata), .instr_err_o(c_err),
    .wr_req_i(1'b0), .wr_addr_i(32'h0), .wr_wdata_i(64'h0),
    .wr_be_i(8'h0), .wr_gnt_o(c_unused_wgnt),
    .mem_req_o(c_unused_req), .mem_we_o(c_unused_we), .mem_addr_o(c_mem_addr),
    .mem_wdata_o(c_unused_wdata), .mem_be_o(c_unused_be), .mem_rdata_i(c_mem_rdata));

  always @(posedge clk) begin
    c_s[0] <= {52'h0, c_mem_addr};
    c_s[1] <= c_s[0];
  end
  assign c_mem_rdata = c_s[1];

  typedef struct {
    logic [31:0] addr;
    logic        exp_err;
    logic [63:0] exp_data;
    logic        exp_mreq;
  } vec_t;

  vec_t vecs [8];
  int   q[$];
  int   b_next, b_grants, b_resps, b_out, b_max;

  initial begin
    vecs[0] = '{32'h8000_0000, 1'b0, 64'h1000, 1'b1};
    vecs[1] = '{32'h8000_0004, 1'b0, 64'h1000, 1'b1};
    vecs[2] = '{32'h8000_0008, 1'b0, 64'h1001, 1'b1};
    vecs[3] = '{32'h8000_7FF8, 1'b0, 64'h1FFF, 1'b1};
    vecs[4] = '{32'h8000_8000, 1'b1, 64'h0,    1'b0};
    vecs[5] = '{32'h7FFF_FFF8, 1'b1, 64'h0,    1'b0};
    vecs[6] = '{32'hFFFF_FFF8, 1'b1, 64'h0,    1'b0};
    vecs[7] = '{32'h8000_0010, 1'b0, 64'h1002, 1'b1};

    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_req = 1'b1; a_addr = 32'h8000_0000;
    a_wr_req = 1'b1; a_wr_addr = 32'h8000_0000; a_wr_wdata = '0; a_wr_be = 8'hFF;
    b_req = 1'b0; b_addr = 32'h8000_0000;
    c_req = 1'b0; c_addr = 32'h8000_0000;

    // Reset state with requests pending
    @(negedge clk); #1;
    chk("rst_gnt", a_gnt, 0);
    chk("rst_wgnt", a_wr_gnt, 0);
    chk("rst_mreq", a_mem_req, 0);
    chk("rst_mwe", a_mem_we, 0);
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_err", a_err, 0);
    chk("rst_rdata", a_rdata, 0);

    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    a_req = 1'b0; a_wr_req = 1'b0; a_wr_be = 8'h00;
    #1 chk("idle_rvalid", a_rvalid, 0);

    // Back-to-back fetches
    @(negedge clk); a_req = 1'b1; a_addr = 32'h8000_0000;
    #1 chk("b2b_gnt0", a_gnt, 1); chk("b2b_mreq0", a_mem_req, 1); chk("b2b_mwe0", a_mem_we, 0);
    @(negedge clk); a_addr = 32'h8000_0008;
    #1 chk("b2b_gnt1", a_gnt, 1); chk("b2b_rv0", a_rvalid, 1);
    chk("b2b_d0", a_rdata, 64'h1000); chk("b2b_e0", a_err, 0);
    @(negedge clk); a_addr = 32'h8000_0010;
    #1 chk("b2b_gnt2", a_gnt, 1); chk("b2b_rv1", a_rvalid, 1); chk("b2b_d1", a_rdata, 64'h1001);
    @(negedge clk); a_req = 1'b0;
    #1 chk("b2b_gnt3", a_gnt, 0); chk("b2b_rv2", a_rvalid, 1); chk("b2b_d2", a_rdata, 64'h1002);
    @(negedge clk);
    #1 chk("b2b_rv_end", a_rvalid, 0);

    // Single-fetch vector table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); a_req = 1'b1; a_addr = vecs[i].addr;
      #1 chk($sformatf("vec%0d_gnt", i), a_gnt, 1);
      chk($sformatf("vec%0d_mreq", i), a_mem_req, vecs[i].exp_mreq);
      @(negedge clk); a_req = 1'b0;
      #1 chk($sformatf("vec%0d_rv", i), a_rvalid, 1);
      chk($sformatf("vec%0d_err", i), a_err, vecs[i].exp_err);
      chk($sformatf("vec%0d_data", i), a_rdata, vecs[i].exp_data);
    end

    // Write collides with fetch to the same word
    @(negedge clk);
    a_wr_req = 1'b1; a_wr_addr = 32'h8000_0010; a_wr_wdata = 64'hDEAD_BEEF_0BAD_F00D; a_wr_be = 8'hFF;
    a_req = 1'b1; a_addr = 32'h8000_0010;
    #1 chk("col_wgnt", a_wr_gnt, 1); chk("col_gnt", a_gnt, 0);
    chk("col_mreq", a_mem_req, 1); chk("col_mwe", a_mem_we, 1);
    chk("col_maddr", a_mem_addr, 2); chk("col_mbe", a_mem_be, 8'hFF);
    @(negedge clk); a_wr_req = 1'b0;
    #1 chk("col_gnt_retry", a_gnt, 1); chk("col_mwe_retry", a_mem_we, 0);
    @(negedge clk); a_req = 1'b0;
    #1 chk("col_rv", a_rvalid, 1); chk("col_data", a_rdata, 64'hDEAD_BEEF_0BAD_F00D);

    // Partial byte-enable write, then read back
    @(negedge clk);
    a_wr_req = 1'b1; a_wr_addr = 32'h8000_0018; a_wr_wdata = '1; a_wr_be = 8'h0F;
    #1 chk("pbe_wgnt", a_wr_gnt, 1);
    @(negedge clk); a_wr_req = 1'b0; a_req = 1'b1; a_addr = 32'h8000_0018;
    #1 chk("pbe_gnt", a_gnt, 1);
    @(negedge clk); a_req = 1'b0;
    #1 chk("pbe_data", a_rdata, 64'h0000_0000_FFFF_FFFF);

    // Out-of-window write is granted but dropped
    @(negedge clk);
    a_wr_req = 1'b1; a_wr_addr = 32'h9000_0000; a_wr_be = 8'hFF;
    #1 chk("oow_wgnt", a_wr_gnt, 1); chk("oow_mreq", a_mem_req, 0); chk("oow_mwe", a_mem_we, 0);
    @(negedge clk); a_wr_req = 1'b0;

    // Outstanding limit on B: grant pattern 1,1,0 repeating
    b_next = 0; b_grants = 0; b_resps = 0; b_out = 0; b_max = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      b_req = (cyc < 9);
      b_addr = 32'h8000_0000 + 32'(8 * b_next);
      #1;
      if (b_rvalid) begin
        b_resps++;
        if (q.size() == 0) begin
          chk("lim_extra_rv", 1, 0);
        end else begin
          chk($sformatf("lim_data%0d", b_resps), b_rdata, 64'(q.pop_front()));
          chk($sformatf("lim_err%0d", b_resps), b_err, 0);
        end
      end
      if (cyc < 9) chk($sformatf("lim_gnt%0d", cyc), b_gnt, (cyc % 3 != 2));
      if (b_gnt) begin
        q.push_back(b_next);
        b_next++;
        b_grants++;
      end
      b_out = b_out + int'(b_gnt) - int'(b_rvalid);
      if (b_out > b_max) b_max = b_out;
    end
    chk("lim_resp_cnt", 64'(b_resps), 64'(b_grants));
    chk("lim_max_out", 64'(b_max), 2);

    // Mid-flight reset on C after two grants
    @(negedge clk); c_req = 1'b1; c_addr = 32'h8000_0000;
    #1 chk("mfr_gnt0", c_gnt, 1);
    @(negedge clk); c_addr = 32'h8000_0008;
    #1 chk("mfr_gnt1", c_gnt, 1); chk("mfr_rv_pre", c_rvalid, 0);
    #1 c_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("mfr_rv_rst%0d", i), c_rvalid, 0);
      chk($sformatf("mfr_gnt_rst%0d", i), c_gnt, 0);
    end
    @(negedge clk); c_rst = 1'b0; c_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("mfr_rv_post%0d", i), c_rvalid, 0);
      @(negedge clk);
    end
    c_req = 1'b1; c_addr = 32'h8000_0028;
    #1 chk("mfr_new_gnt", c_gnt, 1);
    @(negedge clk); c_req = 1'b0;
    #1 chk("mfr_new_rv_early", c_rvalid, 0);
    @(negedge clk);
    #1 chk("mfr_new_rv", c_rvalid, 1); chk("mfr_new_data", c_rdata, 64'h5); chk("mfr_new_err", c_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
